// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the request arbiter
package arb_pkg;
  localparam int NREQ   = 4;
  localparam int ID_W   = 2;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - stateless round-robin winner select (rotated 4-to-2 priority encoder)
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] win,
  output logic [ID_W-1:0] win_id,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [ID_W-1:0]   off;

  always_comb begin
    // rot[0] is the requester at ptr, rot[1] the next one, and so on
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i[ID_W-1:0];
      end
    end
    any    = |req;
    win_id = ptr + off;
    win    = '0;
    if (any) begin
      win[win_id] = 1'b1;
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - round-robin arbiter with one-IDLE gap and hold-time force release
module req_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic                      done,
  output logic [NREQ-1:0]           gnt,
  output logic [arb_pkg::ID_W-1:0]  gnt_id,
  output logic                      valid,
  output logic                      timeout
);
  import arb_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  logic [NREQ-1:0]   pick_win;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic              owner_req;
  logic              hold_hit;
  logic              release_now;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .win    (pick_win),
    .win_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    // gnt_id_q doubles as the owner index while BUSY
    owner_req   = req[gnt_id_q];
    hold_hit    = (hold_cnt_q == HOLD_LAST);
    release_now = done || !owner_req || hold_hit;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d      = pick_win;
          gnt_id_d   = pick_id;
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (release_now) begin
          // timeout only flags a release that nothing else would have caused
          timeout_d = hold_hit && !done && owner_req;
          ptr_d     = gnt_id_q + 1'b1;
          gnt_d     = '0;
          gnt_id_d  = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign valid   = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - self-checking bench for req_arbiter with a behavioural reference model
module tb_req_arbiter;
  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  req_arbiter #(.NREQ(4), .HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource and for how many busy cycles
  bit         m_busy;
  int         m_owner;
  int         m_ptr;
  int         m_held;
  logic [3:0] exp_gnt;
  logic [1:0] exp_id;
  logic       exp_to;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0;
      exp_gnt = '0; exp_id = '0; exp_to = 1'b0;
    end else begin
      exp_to = 1'b0;
      if (m_busy) begin
        m_held = m_held + 1;
        if (done || !req[m_owner] || m_held == HOLD) begin
          exp_to  = !done && req[m_owner];
          m_busy  = 0;
          m_ptr   = (m_owner + 1) % 4;
          exp_gnt = '0;
          exp_id  = '0;
        end
      end else if (req != 4'b0000) begin
        bit found;
        found = 0;
        for (int i = 0; i < 4; i++) begin
          if (!found && req[(m_ptr + i) % 4]) begin
            found   = 1;
            m_owner = (m_ptr + i) % 4;
          end
        end
        m_busy  = 1;
        m_held  = 0;
        exp_gnt = 4'(1 << m_owner);
        exp_id  = 2'(m_owner);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_gnt", gnt, exp_gnt);
      check("model_gnt_id", gnt_id, exp_id);
      check("model_valid", valid, exp_gnt != 4'b0000);
      check("model_timeout", timeout, exp_to);
    end
  end

  int   seen[$];
  int   exp_seq[4];
  logic prev_valid;

  initial begin
    exp_seq = '{2, 3, 0, 1};
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_gnt_id", gnt_id, 2'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_ptr", dut.ptr_q, 2'd0);
    rst = 1'b0; req = 4'b1111;

    @(negedge clk);
    check("first_gnt", gnt, 4'b0001);
    check("first_id", gnt_id, 2'd0);
    done = 1'b1;
    @(negedge clk);
    check("done_rel_gnt", gnt, 4'b0000);
    check("done_rel_ptr", dut.ptr_q, 2'd1);
    done = 1'b0;
    @(negedge clk);
    check("second_gnt", gnt, 4'b0010);
    check("second_id", gnt_id, 2'd1);

    prev_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      if (valid && !prev_valid) seen.push_back(int'(gnt_id));
      prev_valid = valid;
      done = (i % 3 == 1);
    end
    check("rot_count", seen.size(), 4);
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      check("rot_seq", seen[k], exp_seq[k]);
    end

    @(negedge clk);
    req = 4'b0000; done = 1'b0;
    @(negedge clk);
    check("drop1_ptr", dut.ptr_q, 2'd2);
    req = 4'b0100;
    @(negedge clk);
    check("own2_gnt", gnt, 4'b0100);
    check("own2_id", gnt_id, 2'd2);
    req = 4'b0000;
    @(negedge clk);
    check("drop2_gnt", gnt, 4'b0000);
    check("drop2_ptr", dut.ptr_q, 2'd3);
    check("drop2_timeout", timeout, 1'b0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("idle_done_gnt", gnt, 4'b0000);
    check("idle_done_ptr", dut.ptr_q, 2'd3);

    req = 4'b1000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("hold_gnt", gnt, 4'b1000);
      check("hold_timeout", timeout, 1'b0);
    end
    @(negedge clk);
    check("to_gnt", gnt, 4'b0000);
    check("to_pulse", timeout, 1'b1);
    check("to_ptr", dut.ptr_q, 2'd0);
    req = 4'b0000;
    @(negedge clk);
    check("to_one_cycle", timeout, 1'b0);

    req = 4'b1000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("coin_gnt", gnt, 4'b1000);
      if (k == 4) done = 1'b1;
    end
    @(negedge clk);
    check("coin_gnt_rel", gnt, 4'b0000);
    check("coin_timeout", timeout, 1'b0);
    check("coin_ptr", dut.ptr_q, 2'd0);
    done = 1'b0; req = 4'b0001;

    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("odrop_gnt", gnt, 4'b0001);
      if (k == 4) req = 4'b0000;
    end
    @(negedge clk);
    check("odrop_timeout", timeout, 1'b0);
    check("odrop_ptr", dut.ptr_q, 2'd1);

    req = 4'b0010;
    @(negedge clk);
    check("mid_gnt", gnt, 4'b0010);
    req = 4'b0011;
    #2 rst = 1'b1;
    #1;
    check("async_gnt", gnt, 4'b0000);
    check("async_valid", valid, 1'b0);
    check("async_id", gnt_id, 2'd0);
    check("async_timeout", timeout, 1'b0);
    check("async_ptr", dut.ptr_q, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_gnt", gnt, 4'b0001);
    check("post_rst_id", gnt_id, 2'd0);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
